// File: rtl/fifo_w_drain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fifo_w_drain
// Purpose  : Read-side drain for the interconnect write path. Pops a burst
//            length from the command FIFO, then pops len+1 data beats from the
//            data FIFO and presents them on an AXI-style write-data channel.
//            Both FIFOs are read through a show-ahead head/empty/read_en view.
// Ports    : clk, clr (async, active-low)
//            cmd_empty/cmd_head/cmd_read_en : command FIFO read port
//            dat_empty/dat_head/dat_read_en : data FIFO read port
//            wdata/wvalid/wlast/wready      : write-data channel
//            busy       : burst in progress or beat still pending
//            burst_done : one-cycle pulse after the wlast handshake
//            stall_cnt  : saturating count of data-underrun cycles
// Revision : 1.0 - initial release
// ============================================================================
module fifo_w_drain #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int STALL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   cmd_empty,
    input  logic [LEN_WIDTH-1:0]   cmd_head,
    output logic                   cmd_read_en,
    input  logic                   dat_empty,
    input  logic [DATA_WIDTH-1:0]  dat_head,
    output logic                   dat_read_en,
    output logic [DATA_WIDTH-1:0]  wdata,
    output logic                   wvalid,
    output logic                   wlast,
    input  logic                   wready,
    output logic                   busy,
    output logic                   burst_done,
    output logic [STALL_WIDTH-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH:0]     c_beat_one  = {{LEN_WIDTH{1'b0}}, 1'b1};
    localparam logic [STALL_WIDTH-1:0] c_stall_one = {{(STALL_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STALL_WIDTH-1:0] c_stall_max = {STALL_WIDTH{1'b1}};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_len;
    // One bit wider than len so a len of all-ones counts to 2^LEN_WIDTH cleanly.
    logic [LEN_WIDTH:0]     r_beat;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_wvalid;
    logic                   r_wlast;
    logic                   r_burst_done;
    logic [STALL_WIDTH-1:0] r_stall_cnt;

    logic w_slot_free;
    logic w_last_beat;
    logic w_cmd_pop;
    logic w_dat_pop;

    // The output register can accept a new beat when empty or draining now.
    assign w_slot_free = !r_wvalid || wready;
    assign w_last_beat = (r_beat == {1'b0, r_len});

    // ------------------------------------------------------------------------
    // Next-state and FIFO pop decode. Pops are gated by clr so that no FIFO
    // entry is consumed while the registers that would capture it are held.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_pop   = 1'b0;
        w_dat_pop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr && !cmd_empty) begin
                    w_cmd_pop   = 1'b1;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (clr && w_slot_free && !dat_empty) begin
                    w_dat_pop = 1'b1;
                    if (w_last_beat) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Burst bookkeeping and the registered write-data channel.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_len        <= '0;
            r_beat       <= '0;
            r_wdata      <= '0;
            r_wvalid     <= 1'b0;
            r_wlast      <= 1'b0;
            r_burst_done <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_cmd_pop) begin
                r_len  <= cmd_head;
                r_beat <= '0;
            end

            if (w_dat_pop) begin
                r_wdata  <= dat_head;
                r_wvalid <= 1'b1;
                r_wlast  <= w_last_beat;
                r_beat   <= r_beat + c_beat_one;
            end else if (r_wvalid && wready) begin
                // Beat accepted with nothing to replace it; wdata keeps its value.
                r_wvalid <= 1'b0;
                r_wlast  <= 1'b0;
            end

            r_burst_done <= r_wvalid && wready && r_wlast;

            // Count only cycles lost to an empty data FIFO, not to backpressure.
            if ((r_state == S_ACTIVE) && w_slot_free && dat_empty &&
                (r_stall_cnt != c_stall_max)) begin
                r_stall_cnt <= r_stall_cnt + c_stall_one;
            end
        end
    end

    assign cmd_read_en = w_cmd_pop;
    assign dat_read_en = w_dat_pop;
    assign wdata       = r_wdata;
    assign wvalid      = r_wvalid;
    assign wlast       = r_wlast;
    assign busy        = (r_state == S_ACTIVE) || r_wvalid;
    assign burst_done  = r_burst_done;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_w_drain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fifo_w_drain
// Purpose  : Self-checking bench for fifo_w_drain. Queue models stand in for
//            the command and data FIFOs; expected beats go into a scoreboard
//            queue that a negedge monitor pops on every write handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_w_drain;

    localparam int DW = 32;
    localparam int LW = 8;
    localparam int SW = 16;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          cmd_empty = 1'b1;
    logic [LW-1:0] cmd_head = '0;
    logic          cmd_read_en;
    logic          dat_empty = 1'b1;
    logic [DW-1:0] dat_head = '0;
    logic          dat_read_en;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wlast;
    logic          wready = 1'b1;
    logic          busy;
    logic          burst_done;
    logic [SW-1:0] stall_cnt;

    fifo_w_drain #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .STALL_WIDTH(SW)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .cmd_empty  (cmd_empty),
        .cmd_head   (cmd_head),
        .cmd_read_en(cmd_read_en),
        .dat_empty  (dat_empty),
        .dat_head   (dat_head),
        .dat_read_en(dat_read_en),
        .wdata      (wdata),
        .wvalid     (wvalid),
        .wlast      (wlast),
        .wready     (wready),
        .busy       (busy),
        .burst_done (burst_done),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- FIFO models (show-ahead, popped on read_en) -----------
    logic [LW-1:0] cmd_q[$];
    logic [DW-1:0] dat_q[$];
    exp_t          exp_q[$];
    logic          pend_c, pend_d;
    int            dat_pops = 0;

    always @(posedge clk) begin
        cyc++;
        pend_c = cmd_read_en;
        pend_d = dat_read_en;
        #1;
        if (pend_c && cmd_q.size() > 0) void'(cmd_q.pop_front());
        if (pend_d && dat_q.size() > 0) begin
            void'(dat_q.pop_front());
            dat_pops++;
        end
        cmd_empty = (cmd_q.size() == 0);
        cmd_head  = cmd_empty ? '0 : cmd_q[0];
        dat_empty = (dat_q.size() == 0);
        dat_head  = dat_empty ? '0 : dat_q[0];
    end

    // ---------------- Monitor / scoreboard ----------------------------------
    int            hs_cnt = 0;
    int            bd_cnt = 0;
    int            hs_cyc[$];
    exp_t          mon_e;
    logic          p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic [DW-1:0] p_data  = '0;

    always @(negedge clk) begin
        if (clr) begin
            if (wvalid && wready) begin
                hs_cnt++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got wdata 0x%0h wlast %0b, expected no beat", wdata, wlast);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_wdata", wdata, mon_e.d);
                    chk("beat_wlast", wlast, mon_e.l);
                end
            end
            if (burst_done) bd_cnt++;
            if (p_valid && !p_ready) begin
                chk("hold_wvalid", wvalid, 1);
                chk("hold_wdata", wdata, p_data);
                chk("hold_wlast", wlast, p_last);
            end
            if (wvalid && !wready) chk("no_pop_while_stalled", dat_read_en, 0);
            if (dat_empty) chk("no_pop_dat_empty", dat_read_en, 0);
            if (cmd_empty) chk("no_pop_cmd_empty", cmd_read_en, 0);
        end
        p_valid = wvalid && clr;
        p_ready = wready;
        p_data  = wdata;
        p_last  = wlast;
    end

    // ---------------- Stimulus helpers --------------------------------------
    task automatic push_word(input logic [DW-1:0] d, input logic l);
        dat_q.push_back(d);
        exp_q.push_back('{d: d, l: l});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cmd_pop(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_read_en && n < 50);
        if (!cmd_read_en) begin
            checks++;
            errors++;
            $display("FAIL %s: cmd_read_en never seen within 50 cycles", name);
        end
    endtask

    task automatic wait_beat(input string name, input logic [DW-1:0] d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wvalid && wdata == d) && n < 50);
        if (!(wvalid && wdata == d)) begin
            checks++;
            errors++;
            $display("FAIL %s: beat 0x%0h never presented, got 0x%0h", name, d, wdata);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && cmd_q.size() == 0 && !busy) && n < budget);
        if (!(exp_q.size() == 0 && cmd_q.size() == 0 && !busy)) begin
            checks++;
            errors++;
            $display("FAIL %s: not drained after %0d cycles, %0d beats outstanding", name, budget, exp_q.size());
        end
        repeat (2) step();
    endtask

    int            hs0, bd0, pops0, hsn;
    logic [SW-1:0] stall0;

    initial begin
        // ---- reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wlast", wlast, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        step();
        clr = 1'b1;

        // ---- single beat: timing from the command pop
        step();
        bd0 = bd_cnt;
        push_word(32'hA5A5_A5A5, 1'b1);
        cmd_q.push_back(8'd0);
        wait_cmd_pop("single_cmd");
        @(negedge clk);
        @(negedge clk);
        chk("single_wvalid_n2", wvalid, 1);
        chk("single_wlast_n2", wlast, 1);
        chk("single_wdata_n2", wdata, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("single_done_n3", burst_done, 1);
        chk("single_busy_n3", busy, 0);
        drain("single", 50);
        chk("single_bd_count", bd_cnt - bd0, 1);

        // ---- 4-beat burst at full rate
        hs0 = hs_cnt; bd0 = bd_cnt; pops0 = dat_pops; hsn = hs_cyc.size();
        for (int i = 1; i <= 4; i++) push_word(DW'(i), i == 4);
        cmd_q.push_back(8'd3);
        drain("burst4", 100);
        chk("burst4_beats", hs_cnt - hs0, 4);
        chk("burst4_pops", dat_pops - pops0, 4);
        chk("burst4_consecutive", hs_cyc[hsn+3] - hs_cyc[hsn], 3);
        chk("burst4_bd_count", bd_cnt - bd0, 1);

        // ---- backpressure on beat 2
        hs0 = hs_cnt; bd0 = bd_cnt; pops0 = dat_pops;
        for (int i = 1; i <= 4; i++) push_word(32'h10 + DW'(i), i == 4);
        cmd_q.push_back(8'd3);
        wait_beat("bp_first", 32'h11);
        step();
        wready = 1'b0;
        @(negedge clk);
        chk("bp_stall_wvalid", wvalid, 1);
        chk("bp_stall_wdata", wdata, 32'h12);
        chk("bp_stall_wlast", wlast, 0);
        repeat (3) @(posedge clk);
        #2 wready = 1'b1;
        drain("backpressure", 100);
        chk("bp_beats", hs_cnt - hs0, 4);
        chk("bp_pops", dat_pops - pops0, 4);
        chk("bp_bd_count", bd_cnt - bd0, 1);
        chk("bp_no_stall_count", stall_cnt, 0);

        // ---- data underrun: 5 empty cycles mid-burst
        stall0 = stall_cnt; hs0 = hs_cnt;
        push_word(32'h21, 1'b0);
        cmd_q.push_back(8'd3);
        wait_cmd_pop("underrun_cmd");
        repeat (6) @(posedge clk);
        #2;
        push_word(32'h22, 1'b0);
        push_word(32'h23, 1'b0);
        push_word(32'h24, 1'b1);
        drain("underrun", 100);
        chk("underrun_stall_cnt", 64'(int'(stall_cnt) - int'(stall0)), 5);
        chk("underrun_beats", hs_cnt - hs0, 4);

        // ---- back-to-back commands: one bubble between bursts
        bd0 = bd_cnt; hsn = hs_cyc.size();
        push_word(32'hB0, 1'b0);
        push_word(32'hB1, 1'b1);
        push_word(32'hB2, 1'b1);
        cmd_q.push_back(8'd1);
        cmd_q.push_back(8'd0);
        drain("b2b", 100);
        chk("b2b_gap_01", hs_cyc[hsn+1] - hs_cyc[hsn], 1);
        chk("b2b_gap_12", hs_cyc[hsn+2] - hs_cyc[hsn+1], 2);
        chk("b2b_bd_count", bd_cnt - bd0, 2);

        // ---- reset while beat 2 is stalled on the channel
        push_word(32'hC0, 1'b0);
        dat_q.push_back(32'hC1);
        dat_q.push_back(32'hC2);
        dat_q.push_back(32'hC3);
        cmd_q.push_back(8'd3);
        wait_beat("rst_first", 32'hC0);
        step();
        wready = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre_wdata", wdata, 32'hC1);
        #1 clr = 1'b0;
        #1;
        chk("rst_mid_wvalid", wvalid, 0);
        chk("rst_mid_wlast", wlast, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_stall_cnt", stall_cnt, 0);
        repeat (2) step();
        clr = 1'b1;
        wready = 1'b1;
        hs0 = hs_cnt;
        exp_q.push_back('{d: 32'hC2, l: 1'b1});
        cmd_q.push_back(8'd0);
        drain("rst_after", 100);
        chk("rst_after_beats", hs_cnt - hs0, 1);
        chk("rst_fifo_left", dat_q.size(), 1);
        dat_q.delete();
        step();

        // ---- maximum burst length
        hs0 = hs_cnt; bd0 = bd_cnt;
        for (int i = 0; i < 256; i++) push_word(32'h3000_0000 + DW'(i), i == 255);
        cmd_q.push_back(8'd255);
        drain("maxlen", 2000);
        chk("maxlen_beats", hs_cnt - hs0, 256);
        chk("maxlen_bd_count", bd_cnt - bd0, 1);
        chk("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fifo_w_drain.md
# fifo_w_drain

Read-side companion to the interconnect FIFOs: pops burst-length commands from a command FIFO and data beats from a data FIFO, then drives an AXI-style write-data channel (wdata/wvalid/wlast, wready backpressure). It sits between the interconnect's buffered write path and the downstream slave port, with one instance per slave port. Both FIFOs are read through their `head`/`empty`/`read_en` view, so a pop and its data use occur in the same cycle.

## Interface
- DATA_WIDTH, 32, width of data beats / wdata
- LEN_WIDTH, 8, width of burst-length field (beats = len+1)
- STALL_WIDTH, 16, width of saturating underrun-stall counter
- clk  in  1  clock
- clr  in  1  reset; asynchronous, active-low
- cmd_empty  in  1  command FIFO empty
- cmd_head  in  LEN_WIDTH  command FIFO head (burst len, AXI AWLEN encoding)
- cmd_read_en  out  1  command FIFO pop (combinational)
- dat_empty  in  1  data FIFO empty
- dat_head  in  DATA_WIDTH  data FIFO head
- dat_read_en  out  1  data FIFO pop (combinational)
- wdata  out  DATA_WIDTH  registered write data
- wvalid  out  1  registered write valid
- wlast  out  1  registered last-beat flag
- wready  in  1  downstream ready
- busy  out  1  high when state is ACTIVE or wvalid=1
- burst_done  out  1  one-cycle pulse, registered, after the wlast beat handshakes
- stall_cnt  out  STALL_WIDTH  cycles ACTIVE with a free output slot but dat_empty=1; saturates at all-ones

## Operation
- Reset values: state=IDLE, wvalid=0, wlast=0, wdata=0, burst_done=0, stall_cnt=0, len=0, beat=0.
- Output slot free: slot_free = !wvalid || wready.
- IDLE:
  - If !cmd_empty: cmd_read_en=1, len<=cmd_head, beat<=0, state<=ACTIVE.
  - Otherwise hold.
- ACTIVE:
  - dat_read_en = slot_free && !dat_empty.
  - On dat_read_en: wdata<=dat_head, wvalid<=1, wlast<=(beat==len), beat<=beat+1.
  - If beat==len, state<=IDLE.
- No beat loaded while wvalid && wready: wvalid<=0, wlast<=0, wdata holds.
- wvalid && !wready: wdata, wvalid and wlast hold stable. This is an AXI rule and is never violated.
- cmd_read_en and dat_read_en are never asserted when their FIFO reports empty.
- cmd_read_en is never asserted in ACTIVE.
- beat is LEN_WIDTH+1 bits wide, so len=all-ones (256 beats at default) completes without wrap ambiguity.
- burst_done<=wvalid && wready && wlast.
- stall_cnt increments in ACTIVE when slot_free && dat_empty, and saturates at all-ones (no wrap).
- This block never modifies FIFO contents beyond pops. Reset of the FIFOs is independent.

## Timing
- Command popped in cycle N. State is ACTIVE at N+1; the first beat pops at N+1 if data is available, and wvalid is high from N+2.
- Steady-state throughput: 1 beat/cycle while wready=1 and data is available.
- Burst-to-burst: the last beat loads at M; cmd pop at M+1; next burst's first beat loads at M+2. Exactly one wvalid bubble cycle (M+2) when wready is held high.
- A new command may be popped while the previous burst's last beat is still stalled on wready. The next beat waits for slot_free.
- wready is sampled only when wvalid=1. wready while wvalid=0 has no effect.
- burst_done is high in the cycle after the wlast handshake.
- clr asserted mid-burst: all registers go to reset values immediately (asynchronous). wvalid drops without wlast, and the remaining beats stay in the data FIFO.

## Test plan
- Single beat: cmd_head=0, one data word 0xA5A5A5A5, wready=1 -> cmd_read_en at N, wvalid=wlast=1 with wdata=0xA5A5A5A5 at N+2, burst_done at N+3, busy low at N+3.
- 4-beat burst 0x1..0x4, wready=1 -> wvalid for 4 consecutive cycles, wlast only on 0x4, dat_read_en for 4 consecutive cycles.
- Backpressure: 4-beat burst, wready low for 3 cycles on beat 2 -> wdata=0x2/wvalid/wlast=0 held stable for the stall, no extra pops, all 4 beats delivered in order.
- Underrun: cmd len=3, data FIFO gets 1 word, then 5 empty cycles, then 3 words -> stall_cnt=5, wlast on the 4th beat only, no pop while dat_empty=1.
- Back-to-back: cmds len=1 then len=0, data preloaded, wready=1 -> beats B0,B1(last), one bubble cycle, B2(last), two burst_done pulses.
- Reset mid-burst: clr low during beat 2 of 4 -> wvalid/wlast/busy/stall_cnt=0 immediately, state IDLE. After release, a fresh cmd len=0 delivers the next FIFO word as a single last beat.
- Max length: cmd_head=255, 256 words -> exactly 256 handshakes, wlast on beat 256 only.
